// File: rtl/maze_solver_bfs_param_if.sv
// Maze solver bus: serial wall-map input and path/fail output.
interface maze_solver_bfs_param_if #(
  parameter int N = 15
);
  localparam int CW = $clog2(N);

  logic          in_valid;
  logic          maze;
  logic          fwd_order;
  logic          out_valid;
  logic          maze_not_valid;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;

  // Maze loader / path checker side
  modport master (
    output in_valid, maze, fwd_order,
    input  out_valid, maze_not_valid, out_x, out_y
  );

  // Solver side
  modport slave (
    input  in_valid, maze, fwd_order,
    output out_valid, maze_not_valid, out_x, out_y
  );
endinterface

// File: rtl/maze_solver_bfs_param.sv
// Parameterised BFS maze solver: serial N x N wall load, BFS from (1,1) to
// (N-2,N-2) over a circular frontier FIFO with per-cell back-pointers, then
// path trace onto a stack and emission in either order (or a fail pulse).
module maze_solver_bfs_param #(
  parameter int N        = 15,
  parameter int QDEPTH   = 2*N,
  parameter int PATH_MAX = N*N/2+1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  maze_solver_bfs_param_if.slave    bus
);
  localparam int CW    = $clog2(N);
  localparam int NC    = N*N;
  localparam int IW    = $clog2(NC);
  localparam int QW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCW   = $clog2(QDEPTH+1);
  localparam int SW    = $clog2(PATH_MAX+1);
  localparam int S_IDX = N + 1;
  localparam int G_IDX = (N-2)*N + (N-2);
  localparam logic [CW-1:0] S_RC = CW'(1);
  localparam logic [CW-1:0] G_RC = CW'(N-2);

  typedef enum logic [2:0] {LOAD, CHECK, SEARCH, TRACE, EMIT, FAIL} state_t;
  typedef struct packed { logic [CW-1:0] r; logic [CW-1:0] c; } cell_t;

  // Back-pointer codes record the move that reached a cell:
  // 0 = right, 1 = up, 2 = left, 3 = down (same order as push priority).
  state_t state, state_n;

  logic [NC-1:0]  wall;
  logic [NC-1:0]  visited;
  logic [1:0]     bp   [NC];
  cell_t          fifo [QDEPTH];
  cell_t          stk  [PATH_MAX];

  logic [IW-1:0]  cnt;
  logic [QW-1:0]  head, tail;
  logic [QCW-1:0] fcnt;
  logic [SW-1:0]  sp, rd;
  cell_t          cur;
  logic           fwd_q;

  cell_t [3:0]    nb;
  logic  [3:0]    nb_in, nb_ok;
  logic           nb_found;
  logic  [1:0]    nb_dir;
  cell_t          nb_sel, par;
  logic  [1:0]    bp_cur;
  logic           at_goal, at_start, fifo_full, fifo_empty, trace_full;
  logic           end_wall, emit_last, push, pop;
  logic  [SW-1:0] emit_idx;

  function automatic logic [IW-1:0] idx(input cell_t p);
    return IW'(p.r) * IW'(N) + IW'(p.c);
  endfunction

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (p == QW'(QDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Neighbour coordinates of cur in push-priority order; range test done
  // separately so wrapped coordinates are never trusted.
  always_comb begin
    nb[0].r = cur.r;        nb[0].c = cur.c + 1'b1;
    nb[1].r = cur.r - 1'b1; nb[1].c = cur.c;
    nb[2].r = cur.r;        nb[2].c = cur.c - 1'b1;
    nb[3].r = cur.r + 1'b1; nb[3].c = cur.c;
    nb_in[0] = (cur.c != CW'(N-1));
    nb_in[1] = (cur.r != '0);
    nb_in[2] = (cur.c != '0);
    nb_in[3] = (cur.r != CW'(N-1));
  end

  for (genvar d = 0; d < 4; d++) begin : g_nb
    assign nb_ok[d] = nb_in[d] && !wall[idx(nb[d])] && !visited[idx(nb[d])];
  end

  // First eligible neighbour wins; parent of cur undoes its recorded move.
  always_comb begin
    nb_found = |nb_ok;
    nb_dir   = 2'd0;
    for (int d = 3; d >= 0; d--)
      if (nb_ok[d]) nb_dir = 2'(d);
    nb_sel = nb[nb_dir];
    bp_cur = bp[idx(cur)];
    par    = cur;
    case (bp_cur)
      2'd0:    par.c = cur.c - 1'b1;
      2'd1:    par.r = cur.r + 1'b1;
      2'd2:    par.c = cur.c + 1'b1;
      default: par.r = cur.r - 1'b1;
    endcase
  end

  assign at_goal    = (cur.r == G_RC) && (cur.c == G_RC);
  assign at_start   = (cur.r == S_RC) && (cur.c == S_RC);
  assign fifo_full  = (fcnt == QCW'(QDEPTH));
  assign fifo_empty = (fcnt == '0);
  assign trace_full = (sp == SW'(PATH_MAX));
  assign end_wall   = wall[S_IDX] | wall[G_IDX];
  assign emit_idx   = fwd_q ? sp - 1'b1 : rd;
  assign emit_last  = fwd_q ? (sp == SW'(1)) : (rd == sp - 1'b1);
  assign push       = (state == SEARCH) && !at_goal && nb_found && !fifo_full;
  assign pop        = (state == SEARCH) && !at_goal && !nb_found && !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      LOAD:   if (bus.in_valid && cnt == IW'(NC-1)) state_n = CHECK;
      CHECK:  state_n = end_wall ? FAIL : SEARCH;
      SEARCH: begin
        if (at_goal)                      state_n = TRACE;
        else if (nb_found && fifo_full)   state_n = FAIL;
        else if (!nb_found && fifo_empty) state_n = FAIL;
      end
      TRACE: begin
        if (trace_full)    state_n = FAIL;
        else if (at_start) state_n = EMIT;
      end
      EMIT:   if (emit_last) state_n = LOAD;
      FAIL:   state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // Control/datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt                <= '0;
      visited            <= '0;
      head               <= '0;
      tail               <= '0;
      fcnt               <= '0;
      sp                 <= '0;
      rd                 <= '0;
      cur                <= '0;
      fwd_q              <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.maze_not_valid <= 1'b0;
      bus.out_x          <= '0;
      bus.out_y          <= '0;
    end else begin
      bus.out_valid      <= 1'b0;
      bus.maze_not_valid <= 1'b0;
      bus.out_x          <= '0;
      bus.out_y          <= '0;
      case (state)
        LOAD: if (bus.in_valid) begin
          if (cnt == '0) fwd_q <= bus.fwd_order;
          cnt <= cnt + 1'b1;
        end
        CHECK: if (!end_wall) begin
          visited[S_IDX] <= 1'b1;
          cur.r          <= S_RC;
          cur.c          <= S_RC;
        end
        SEARCH: begin
          if (push) begin
            visited[idx(nb_sel)] <= 1'b1;
            tail                 <= qinc(tail);
            fcnt                 <= fcnt + 1'b1;
          end else if (pop) begin
            cur  <= fifo[head];
            head <= qinc(head);
            fcnt <= fcnt - 1'b1;
          end
        end
        TRACE: if (!trace_full) begin
          sp <= sp + 1'b1;
          if (!at_start) cur <= par;
        end
        EMIT: begin
          bus.out_valid <= 1'b1;
          bus.out_x     <= stk[emit_idx].c;
          bus.out_y     <= stk[emit_idx].r;
          if (fwd_q) sp <= sp - 1'b1;
          else       rd <= rd + 1'b1;
          if (emit_last) begin
            cnt     <= '0;
            visited <= '0;
            head    <= '0;
            tail    <= '0;
            fcnt    <= '0;
            sp      <= '0;
            rd      <= '0;
          end
        end
        FAIL: begin
          bus.out_valid      <= 1'b1;
          bus.maze_not_valid <= 1'b1;
          cnt                <= '0;
          visited            <= '0;
          head               <= '0;
          tail               <= '0;
          fcnt               <= '0;
          sp                 <= '0;
          rd                 <= '0;
        end
        default: ;
      endcase
    end
  end

  // Storage arrays: wall map, frontier FIFO, back-pointers, path stack
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid) wall[cnt] <= bus.maze;
    if (push) begin
      fifo[tail]      <= nb_sel;
      bp[idx(nb_sel)] <= nb_dir;
    end
    if (state == TRACE && !trace_full) stk[sp] <= cur;
  end

endmodule

// File: tb/tb_maze_solver_bfs_param.sv
// Bench for maze_solver_bfs_param: three instances (N=7, N=7 with a tiny
// FIFO, N=15) checked by per-instance scoreboards fed from a queue-based
// BFS reference model.
module tb_maze_solver_bfs_param;
  typedef struct { bit f; int x; int y; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic iv7, mz7, fw7, iv15, mz15, fw15;

  always #5 clk = ~clk;

  maze_solver_bfs_param_if #(.N(7))  ifa ();
  maze_solver_bfs_param_if #(.N(7))  ifb ();
  maze_solver_bfs_param_if #(.N(15)) ifc ();

  assign ifa.in_valid = iv7;  assign ifa.maze = mz7;  assign ifa.fwd_order = fw7;
  assign ifb.in_valid = iv7;  assign ifb.maze = mz7;  assign ifb.fwd_order = fw7;
  assign ifc.in_valid = iv15; assign ifc.maze = mz15; assign ifc.fwd_order = fw15;

  maze_solver_bfs_param #(.N(7))              dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  maze_solver_bfs_param #(.N(7), .QDEPTH(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  maze_solver_bfs_param #(.N(15))             dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int   tests = 0;
  int   fails = 0;
  exp_t qa[$], qb[$], qc[$], mres[$];
  bit   mz[];

  task automatic chk(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic f, input int x, input int y);
    tests++;
    if (f !== e.f || x != e.x || y != e.y) begin
      fails++;
      $display("FAIL %s: got nv=%0d (x=%0d,y=%0d), want nv=%0d (x=%0d,y=%0d)",
               nm, f, x, y, e.f, e.x, e.y);
    end
  endtask

  // Reference: plain BFS over the grid, frontier bounded by qd, path bounded
  // by n*n/2+1; result is the expected output sequence in mres.
  function automatic void model(input int n, input int qd, input bit fwd);
    int par[]; bit vis[]; int q[$]; int path[$];
    int dr[4]; int dc[4];
    int cur, goal, pmax, p;
    bit bad;
    dr = '{0, -1, 0, 1};
    dc = '{1, 0, -1, 0};
    mres.delete();
    pmax = n*n/2 + 1;
    goal = (n-2)*n + (n-2);
    cur  = n + 1;
    bad  = mz[cur] || mz[goal];
    if (!bad) begin
      par = new[n*n];
      vis = new[n*n];
      vis[cur] = 1'b1;
      while (cur != goal && !bad) begin
        for (int d = 0; d < 4 && !bad; d++) begin
          int r = cur / n + dr[d];
          int c = cur % n + dc[d];
          if (r >= 0 && r < n && c >= 0 && c < n && !mz[r*n+c] && !vis[r*n+c]) begin
            if (q.size() == qd) bad = 1'b1;
            else begin
              q.push_back(r*n+c);
              vis[r*n+c] = 1'b1;
              par[r*n+c] = cur;
            end
          end
        end
        if (!bad) begin
          if (q.size() == 0) bad = 1'b1;
          else cur = q.pop_front();
        end
      end
    end
    if (!bad) begin
      p = goal;
      forever begin
        path.push_front(p);
        if (p == n + 1) break;
        p = par[p];
      end
      if (path.size() > pmax) bad = 1'b1;
    end
    if (bad) mres.push_back('{1'b1, 0, 0});
    else
      for (int k = 0; k < path.size(); k++) begin
        int c2 = fwd ? path[k] : path[path.size()-1-k];
        mres.push_back('{1'b0, c2 % n, c2 / n});
      end
  endfunction

  task automatic gen_open(input int n);
    mz = new[n*n];
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        mz[r*n+c] = (r == 0 || c == 0 || r == n-1 || c == n-1);
  endtask

  task automatic gen_rand(input int n);
    gen_open(n);
    for (int r = 1; r < n-1; r++)
      for (int c = 1; c < n-1; c++)
        mz[r*n+c] = ($urandom_range(0, 99) < 28);
    if ($urandom_range(0, 9) != 0) mz[n+1] = 1'b0;
    if ($urandom_range(0, 9) != 0) mz[(n-2)*n+n-2] = 1'b0;
  endtask

  task automatic stream(input int n, input bit fwd);
    for (int i = 0; i < n*n; i++) begin
      @(negedge clk);
      if (n == 7) begin iv7 = 1'b1; mz7 = mz[i]; fw7 = fwd; end
      else        begin iv15 = 1'b1; mz15 = mz[i]; fw15 = fwd; end
    end
    @(negedge clk);
    iv7 = 1'b0; mz7 = 1'b0; iv15 = 1'b0; mz15 = 1'b0;
  endtask

  // Load expectations, stream the maze, then wait (bounded) for the
  // scoreboards to drain; also checks contiguity and first-output latency.
  task automatic run_maze(input int n, input bit fwd, input int maxlat);
    int L, tf, tl, cyc, budget, sz;
    bit done;
    if (n == 7) begin
      model(7, 14, fwd); foreach (mres[i]) qa.push_back(mres[i]); L = mres.size();
      model(7, 2, fwd);  foreach (mres[i]) qb.push_back(mres[i]);
    end else begin
      model(15, 30, fwd); foreach (mres[i]) qc.push_back(mres[i]); L = mres.size();
    end
    stream(n, fwd);
    budget = 4*n*n + (n*n/2+1) + L + 10;
    tf = -1; tl = -1; cyc = 0; done = 1'b0;
    while (!done && cyc < budget) begin
      @(posedge clk); #2;
      cyc++;
      sz = (n == 7) ? qa.size() : qc.size();
      if (tf < 0 && sz < L)  tf = cyc;
      if (tl < 0 && sz == 0) tl = cyc;
      done = (n == 7) ? (qa.size() == 0 && qb.size() == 0) : (qc.size() == 0);
    end
    chk($sformatf("drain_n%0d", n), int'(done), 1);
    if (done) begin
      chk($sformatf("contiguous_n%0d", n), tl - tf, L - 1);
      chk($sformatf("latency_n%0d_le_%0d", n, maxlat), int'((tf - 1) <= maxlat), 1);
    end
    repeat (2*n) @(negedge clk);
  endtask

  // Scoreboard monitors: pop and compare whenever an instance emits.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifa.out_valid === 1'b1) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL A_out: unexpected output nv=%0d (%0d,%0d), none expected",
                 ifa.maze_not_valid, ifa.out_x, ifa.out_y);
      end else cmp("A_out", qa.pop_front(), ifa.maze_not_valid, int'(ifa.out_x), int'(ifa.out_y));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifb.out_valid === 1'b1) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL B_out: unexpected output nv=%0d (%0d,%0d), none expected",
                 ifb.maze_not_valid, ifb.out_x, ifb.out_y);
      end else cmp("B_out", qb.pop_front(), ifb.maze_not_valid, int'(ifb.out_x), int'(ifb.out_y));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.out_valid === 1'b1) begin
      if (qc.size() == 0) begin
        tests++; fails++;
        $display("FAIL C_out: unexpected output nv=%0d (%0d,%0d), none expected",
                 ifc.maze_not_valid, ifc.out_x, ifc.out_y);
      end else cmp("C_out", qc.pop_front(), ifc.maze_not_valid, int'(ifc.out_x), int'(ifc.out_y));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, guard;
    rst_n = 1'b0;
    iv7 = 1'b0; mz7 = 1'b0; fw7 = 1'b0;
    iv15 = 1'b0; mz15 = 1'b0; fw15 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_A_outs", int'({ifa.out_valid, ifa.maze_not_valid, ifa.out_x, ifa.out_y}), 0);
    chk("reset_B_outs", int'({ifb.out_valid, ifb.maze_not_valid, ifb.out_x, ifb.out_y}), 0);
    chk("reset_C_outs", int'({ifc.out_valid, ifc.maze_not_valid, ifc.out_x, ifc.out_y}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Open 5x5 interior: A finds a 9-cell path, B (QDEPTH=2) overflows.
    gen_open(7);
    run_maze(7, 1'b1, 4*49 + 25);
    run_maze(7, 1'b0, 4*49 + 25);

    // START is a wall: single fail pulse within 3 cycles.
    gen_open(7);
    mz[8] = 1'b1;
    run_maze(7, 1'b1, 3);

    // N=15 with GOAL boxed in, then the open maze.
    gen_open(15);
    mz[12*15+13] = 1'b1;
    mz[13*15+12] = 1'b1;
    run_maze(15, 1'b1, 4*225 + 113);
    gen_open(15);
    run_maze(15, 1'b0, 4*225 + 113);

    // Reset during the third emitted cell.
    gen_open(7);
    model(7, 14, 1'b1); foreach (mres[i]) qa.push_back(mres[i]); L = mres.size();
    model(7, 2, 1'b1);  foreach (mres[i]) qb.push_back(mres[i]);
    stream(7, 1'b1);
    guard = 0;
    while (qa.size() > L - 3 && guard < 1000) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("reach_third_emit", qa.size(), L - 3);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midemit_reset_A_outs", int'({ifa.out_valid, ifa.maze_not_valid, ifa.out_x, ifa.out_y}), 0);
    chk("midemit_reset_B_outs", int'({ifb.out_valid, ifb.maze_not_valid, ifb.out_x, ifb.out_y}), 0);
    rst_n = 1'b1;
    qa.delete();
    qb.delete();
    @(negedge clk);
    run_maze(7, 1'b0, 4*49 + 25);

    // Random mazes on both sizes.
    for (int t = 0; t < 8; t++) begin
      gen_rand(7);
      run_maze(7, 1'($urandom_range(0, 1)), 4*49 + 25);
    end
    for (int t = 0; t < 4; t++) begin
      gen_rand(15);
      run_maze(15, 1'($urandom_range(0, 1)), 4*225 + 113);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
